// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 one-wire LED encoder.
// Defining WS2812_RGBW_EN selects 32-bit GRBW pixels; otherwise pixels are 24-bit GRB.
package ws2812_pkg;

`ifdef WS2812_RGBW_EN
  localparam int PIX_W = 32;
`else
  localparam int PIX_W = 24;
`endif

  localparam int BIT_IDX_W = $clog2(PIX_W);

  localparam int DEF_T0H_CYCLES   = 20;
  localparam int DEF_T1H_CYCLES   = 40;
  localparam int DEF_BIT_CYCLES   = 63;
  localparam int DEF_LATCH_CYCLES = 15000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_LATCH
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Bit-period counter and high-time compare for one WS2812 bit slot.
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int CNT_W      = 6
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_bit,
  output logic o_high,
  output logic o_bit_end
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST_CNT);

  // Counter sits at zero outside SHIFT so every bit period starts cleanly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_end = i_run && w_wrap;
  assign o_high    = (r_cnt < (i_bit ? T1H : T0H));

endmodule

// File: rtl/ws2812_encoder.sv
// WS2812 serial encoder: one-entry pixel holding register feeding an MSB-first bit shifter.
// Pixel width follows ws2812_pkg (WS2812_RGBW_EN selects 32-bit GRBW).
module ws2812_encoder
  import ws2812_pkg::*;
#(
  parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             pixel_valid_i,
  output logic             pixel_ready_o,
  input  logic [PIX_W-1:0] pixel_data_i,
  input  logic             pixel_last_i,
  output logic             led_ctl_o,
  output logic             busy_o,
  output logic             underrun_o
);

  localparam int MAX_CYC = max_of(max_of(T0H_CYCLES, T1H_CYCLES),
                                  max_of(BIT_CYCLES, LATCH_CYCLES));
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0]     WAIT_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [BIT_IDX_W-1:0] MSB_IDX   = BIT_IDX_W'(PIX_W - 1);

  state_t               r_state;
  state_t               w_next;
  logic                 r_full;
  logic                 r_hold_last;
  logic [PIX_W-1:0]     r_hold;
  logic [PIX_W-1:0]     r_shift;
  logic                 r_cur_last;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic [CNT_W-1:0]     r_wait_cnt;
  logic                 r_led;
  logic                 r_underrun;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_underrun;
  logic                 w_run;
  logic                 w_high;
  logic                 w_bit_end;
  logic                 w_wait_done;
  logic                 w_led_d;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    assert (T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)
      else $error("ws2812_encoder: require T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end
`endif

  ws2812_bit_timer #(
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .BIT_CYCLES (BIT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_bit_timer (
    .i_clk     (clk_i),
    .i_rst_n   (resetn_i),
    .i_run     (w_run),
    .i_bit     (r_shift[PIX_W-1]),
    .o_high    (w_high),
    .o_bit_end (w_bit_end)
  );

  assign w_accept      = pixel_valid_i && !r_full;
  assign w_wait_done   = (r_wait_cnt == WAIT_LAST);
  assign pixel_ready_o = !r_full;
  assign led_ctl_o     = r_led;
  assign underrun_o    = r_underrun;

  // A new pixel wins over a simultaneous load so the register ends full.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_full      <= 1'b0;
      r_hold      <= '0;
      r_hold_last <= 1'b0;
    end else if (w_accept) begin
      r_full      <= 1'b1;
      r_hold      <= pixel_data_i;
      r_hold_last <= pixel_last_i;
    end else if (w_load) begin
      r_full      <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_shift    <= '0;
      r_cur_last <= 1'b0;
      r_bit_idx  <= '0;
    end else if (w_load) begin
      r_shift    <= r_hold;
      r_cur_last <= r_hold_last;
      r_bit_idx  <= MSB_IDX;
    end else if (w_bit_end) begin
      r_shift    <= {r_shift[PIX_W-2:0], 1'b0};
      r_bit_idx  <= r_bit_idx - 1'b1;
    end
  end

  // Shared dwell counter for GAP and LATCH; restarts on every state entry.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_GAP || r_state == ST_LATCH) && w_next == r_state) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_underrun = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_full) begin
          w_next = ST_SHIFT;
          w_load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_bit_end && r_bit_idx == '0) begin
          if (r_cur_last) begin
            w_next = ST_LATCH;
          end else if (r_full) begin
            w_load = 1'b1;
          end else begin
            w_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (r_full) begin
          w_next = ST_SHIFT;
          w_load = 1'b1;
        end else if (w_wait_done) begin
          w_next     = ST_IDLE;
          w_underrun = 1'b1;
        end
      end
      ST_LATCH: begin
        if (w_wait_done) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_run   = (r_state == ST_SHIFT);
    w_led_d = w_run && w_high;
    busy_o  = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_led      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_led      <= w_led_d;
      r_underrun <= w_underrun;
    end
  end

endmodule

// File: tb/tb_ws2812_encoder.sv
// Directed bench for ws2812_encoder: bit timing, back-to-back pixels, gap, underrun and reset.
module tb_ws2812_encoder;
  import ws2812_pkg::*;

  localparam int T0H      = 20;
  localparam int T1H      = 40;
  localparam int BITC     = 63;
  localparam int LATCH    = 15000;
  localparam int MAX_WAIT = 20000;

  logic             clk_i         = 1'b0;
  logic             resetn_i      = 1'b0;
  logic             pixel_valid_i = 1'b0;
  logic [PIX_W-1:0] pixel_data_i  = '0;
  logic             pixel_last_i  = 1'b0;
  logic             pixel_ready_o;
  logic             led_ctl_o;
  logic             busy_o;
  logic             underrun_o;

  int   vectors        = 0;
  int   miscompares    = 0;
  int   readyRises     = 0;
  int   underrunPulses = 0;
  logic prevReady      = 1'b0;

  ws2812_encoder #(
    .T0H_CYCLES   (T0H),
    .T1H_CYCLES   (T1H),
    .BIT_CYCLES   (BITC),
    .LATCH_CYCLES (LATCH)
  ) dut (
    .clk_i         (clk_i),
    .resetn_i      (resetn_i),
    .pixel_valid_i (pixel_valid_i),
    .pixel_ready_o (pixel_ready_o),
    .pixel_data_i  (pixel_data_i),
    .pixel_last_i  (pixel_last_i),
    .led_ctl_o     (led_ctl_o),
    .busy_o        (busy_o),
    .underrun_o    (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (pixel_ready_o === 1'b1 && prevReady !== 1'b1) readyRises++;
    prevReady = pixel_ready_o;
    if (underrun_o === 1'b1) underrunPulses++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int exp_high(input logic b);
    return b ? T1H : T0H;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    pixel_valid_i = 1'b0;
    pixel_last_i  = 1'b0;
    resetn_i      = 1'b0;
    repeat (2) tick();
    resetn_i = 1'b1;
  endtask

  // Holds valid until the pixel is taken; returns at #1 after the acceptance edge.
  task automatic offer_pixel(input logic [PIX_W-1:0] d, input logic last,
                             output bit ok, output int waits);
    ok            = 1'b0;
    waits         = 0;
    pixel_valid_i = 1'b1;
    pixel_data_i  = d;
    pixel_last_i  = last;
    while (!ok && waits < MAX_WAIT) begin
      if (pixel_ready_o === 1'b1) begin
        tick();
        ok = 1'b1;
      end else begin
        tick();
        waits++;
      end
    end
    pixel_valid_i = 1'b0;
    pixel_last_i  = 1'b0;
  endtask

  // Samples one bit slot; the high cycles must form a single leading run.
  task automatic capture_bit(output int highs, output bit shapeOk);
    bit seenLow;
    highs   = 0;
    shapeOk = 1'b1;
    seenLow = 1'b0;
    for (int c = 0; c < BITC; c++) begin
      tick();
      if (led_ctl_o === 1'b1) begin
        highs++;
        if (seenLow) shapeOk = 1'b0;
      end else begin
        seenLow = 1'b1;
        if (led_ctl_o !== 1'b0) shapeOk = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    resetn_i = 1'b0;
    repeat (3) tick();
    vectors++;
    if (led_ctl_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_led: got %b expected 0", led_ctl_o); end
    vectors++;
    if (pixel_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", pixel_ready_o); end
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    vectors++;
    if (underrun_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun_o); end
    resetn_i = 1'b1;
    tick();
    vectors++;
    if ({busy_o, pixel_ready_o, led_ctl_o} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL post_release {busy,ready,led}: got %b expected 010", {busy_o, pixel_ready_o, led_ctl_o});
    end
  endtask

  task automatic test_single_pixel();
    logic [PIX_W-1:0] px;
    bit ok, shapeOk, lowOk;
    int waits, highs;
    px = PIX_W'(24'hFF0055);
    offer_pixel(px, 1'b1, ok, waits);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL single_accept: got %b expected 1", ok); end
    tick();
    vectors++;
    if ({led_ctl_o, busy_o} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL single_latency {led,busy}: got %b expected 01", {led_ctl_o, busy_o});
    end
    for (int b = PIX_W - 1; b >= 0; b--) begin
      capture_bit(highs, shapeOk);
      vectors++;
      if (highs !== exp_high(px[b]) || !shapeOk) begin
        miscompares++;
        $display("[TB] FAIL single_bit%0d: got %0d high cycles (shape %0b) expected %0d", b, highs, shapeOk, exp_high(px[b]));
      end
    end
    lowOk = 1'b1;
    for (int c = 0; c < LATCH - 1; c++) begin
      tick();
      if (led_ctl_o !== 1'b0 || busy_o !== 1'b1) lowOk = 1'b0;
    end
    vectors++;
    if (lowOk !== 1'b1) begin miscompares++; $display("[TB] FAIL latch_low: got %b expected 1", lowOk); end
    tick();
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL latch_end_busy: got %b expected 0", busy_o); end
    vectors++;
    if (pixel_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL latch_end_ready: got %b expected 1", pixel_ready_o); end
  endtask

  task automatic test_back_to_back();
    logic [PIX_W-1:0] pxs [3];
    bit ok0, ok1, ok2, shapeOk;
    int waits, highs, riseBase;
    pxs[0] = PIX_W'(24'hA5C31E);
    pxs[1] = PIX_W'(24'h00FF00);
    pxs[2] = PIX_W'(24'h13579B);
    offer_pixel(pxs[0], 1'b0, ok0, waits);
    riseBase = readyRises;
    fork
      begin
        offer_pixel(pxs[1], 1'b0, ok1, waits);
        offer_pixel(pxs[2], 1'b1, ok2, waits);
      end
      begin
        tick();
        vectors++;
        if (led_ctl_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_latency: got %b expected 0", led_ctl_o); end
        for (int p = 0; p < 3; p++) begin
          for (int b = PIX_W - 1; b >= 0; b--) begin
            capture_bit(highs, shapeOk);
            vectors++;
            if (highs !== exp_high(pxs[p][b]) || !shapeOk) begin
              miscompares++;
              $display("[TB] FAIL b2b_px%0d_bit%0d: got %0d high cycles (shape %0b) expected %0d",
                       p, b, highs, shapeOk, exp_high(pxs[p][b]));
            end
          end
        end
      end
    join
    vectors++;
    if ({ok0, ok1, ok2} !== 3'b111) begin miscompares++; $display("[TB] FAIL b2b_accept: got %b expected 111", {ok0, ok1, ok2}); end
    vectors++;
    if (readyRises - riseBase !== 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_ready_rises: got %0d expected 3", readyRises - riseBase);
    end
    vectors++;
    if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_latch_busy: got %b expected 1", busy_o); end
    apply_reset();
  endtask

  task automatic test_gap();
    logic [PIX_W-1:0] p1, p2;
    bit ok, shapeOk, gapOk;
    int waits, highs, pulseBase;
    p1 = PIX_W'(24'h0F0F0F);
    p2 = PIX_W'(24'hF0F0F0);
    offer_pixel(p1, 1'b0, ok, waits);
    tick();
    for (int b = PIX_W - 1; b >= 0; b--) begin
      capture_bit(highs, shapeOk);
      vectors++;
      if (highs !== exp_high(p1[b]) || !shapeOk) begin
        miscompares++;
        $display("[TB] FAIL gap_p1_bit%0d: got %0d high cycles (shape %0b) expected %0d", b, highs, shapeOk, exp_high(p1[b]));
      end
    end
    pulseBase = underrunPulses;
    gapOk = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (led_ctl_o !== 1'b0 || busy_o !== 1'b1) gapOk = 1'b0;
    end
    vectors++;
    if (gapOk !== 1'b1) begin miscompares++; $display("[TB] FAIL gap_low_busy: got %b expected 1", gapOk); end
    offer_pixel(p2, 1'b1, ok, waits);
    vectors++;
    if (ok !== 1'b1 || waits !== 0) begin
      miscompares++;
      $display("[TB] FAIL gap_accept: got ok=%b waits=%0d expected ok=1 waits=0", ok, waits);
    end
    tick();
    vectors++;
    if (led_ctl_o !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_resume_latency: got %b expected 0", led_ctl_o); end
    for (int b = PIX_W - 1; b >= 0; b--) begin
      capture_bit(highs, shapeOk);
      vectors++;
      if (highs !== exp_high(p2[b]) || !shapeOk) begin
        miscompares++;
        $display("[TB] FAIL gap_p2_bit%0d: got %0d high cycles (shape %0b) expected %0d", b, highs, shapeOk, exp_high(p2[b]));
      end
    end
    vectors++;
    if (underrunPulses - pulseBase !== 0) begin
      miscompares++;
      $display("[TB] FAIL gap_no_underrun: got %0d pulses expected 0", underrunPulses - pulseBase);
    end
    apply_reset();
  endtask

  task automatic test_underrun();
    logic [PIX_W-1:0] px;
    bit ok, shapeOk, quietOk;
    int waits, highs, pulseBase;
    px = PIX_W'(24'h800001);
    offer_pixel(px, 1'b0, ok, waits);
    tick();
    for (int b = PIX_W - 1; b >= 0; b--) begin
      capture_bit(highs, shapeOk);
      vectors++;
      if (highs !== exp_high(px[b]) || !shapeOk) begin
        miscompares++;
        $display("[TB] FAIL underrun_bit%0d: got %0d high cycles (shape %0b) expected %0d", b, highs, shapeOk, exp_high(px[b]));
      end
    end
    pulseBase = underrunPulses;
    quietOk = 1'b1;
    for (int c = 0; c < LATCH - 1; c++) begin
      tick();
      if (underrun_o !== 1'b0 || busy_o !== 1'b1 || led_ctl_o !== 1'b0) quietOk = 1'b0;
    end
    vectors++;
    if (quietOk !== 1'b1) begin miscompares++; $display("[TB] FAIL underrun_quiet: got %b expected 1", quietOk); end
    tick();
    vectors++;
    if ({underrun_o, busy_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL underrun_pulse {underrun,busy}: got %b expected 10", {underrun_o, busy_o});
    end
    tick();
    vectors++;
    if (underrun_o !== 1'b0) begin miscompares++; $display("[TB] FAIL underrun_clear: got %b expected 0", underrun_o); end
    vectors++;
    if (underrunPulses - pulseBase !== 1) begin
      miscompares++;
      $display("[TB] FAIL underrun_count: got %0d expected 1", underrunPulses - pulseBase);
    end
  endtask

  task automatic test_reset_midbit();
    logic [PIX_W-1:0] px, px2;
    bit ok, shapeOk;
    int waits, highs;
    px = '0;
    px[PIX_W-1] = 1'b1;
    px2 = PIX_W'(24'hC3A55A);
    offer_pixel(px, 1'b1, ok, waits);
    tick();
    repeat (10) tick();
    vectors++;
    if (led_ctl_o !== 1'b1) begin miscompares++; $display("[TB] FAIL midbit_high: got %b expected 1", led_ctl_o); end
    #2;
    resetn_i = 1'b0;
    #1;
    vectors++;
    if (led_ctl_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midbit_reset_led: got %b expected 0", led_ctl_o); end
    vectors++;
    if ({busy_o, pixel_ready_o, underrun_o} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL midbit_reset {busy,ready,underrun}: got %b expected 010", {busy_o, pixel_ready_o, underrun_o});
    end
    repeat (2) tick();
    resetn_i = 1'b1;
    offer_pixel(px2, 1'b1, ok, waits);
    vectors++;
    if (ok !== 1'b1 || waits !== 0) begin
      miscompares++;
      $display("[TB] FAIL midbit_first_accept: got ok=%b waits=%0d expected ok=1 waits=0", ok, waits);
    end
    tick();
    vectors++;
    if (led_ctl_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midbit_latency: got %b expected 0", led_ctl_o); end
    for (int b = PIX_W - 1; b >= 0; b--) begin
      capture_bit(highs, shapeOk);
      vectors++;
      if (highs !== exp_high(px2[b]) || !shapeOk) begin
        miscompares++;
        $display("[TB] FAIL midbit_px_bit%0d: got %0d high cycles (shape %0b) expected %0d", b, highs, shapeOk, exp_high(px2[b]));
      end
    end
    apply_reset();
  endtask

`ifdef WS2812_RGBW_EN
  task automatic test_rgbw();
    logic [PIX_W-1:0] px;
    bit ok, shapeOk;
    int waits, highs;
    px = 32'h0000_0001;
    offer_pixel(px, 1'b1, ok, waits);
    tick();
    for (int b = PIX_W - 1; b >= 0; b--) begin
      capture_bit(highs, shapeOk);
      vectors++;
      if (highs !== exp_high(px[b]) || !shapeOk) begin
        miscompares++;
        $display("[TB] FAIL rgbw_bit%0d: got %0d high cycles (shape %0b) expected %0d", b, highs, shapeOk, exp_high(px[b]));
      end
    end
    vectors++;
    if ({busy_o, led_ctl_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL rgbw_latch {busy,led}: got %b expected 10", {busy_o, led_ctl_o});
    end
    apply_reset();
  endtask
`endif

  initial begin
    $display("[TB] ws2812_encoder bench, PIX_W=%0d", PIX_W);
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_gap();
    test_underrun();
    test_reset_midbit();
`ifdef WS2812_RGBW_EN
    test_rgbw();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ws2812_encoder.md
WS2812_ENCODER -- requirements
Module: ws2812_encoder

Interface
REQ-001 SHALL have parameter T0H_CYCLES, default 20, meaning high time of a 0 bit in clk_i cycles.
REQ-002 SHALL have parameter T1H_CYCLES, default 40, meaning high time of a 1 bit in clk_i cycles.
REQ-003 SHALL have parameter BIT_CYCLES, default 63, meaning total bit period in clk_i cycles.
REQ-004 SHALL have parameter LATCH_CYCLES, default 15000, meaning low time that terminates a frame.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port resetn_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pixel_valid_i, input, 1, upstream pixel offered.
REQ-008 SHALL have port pixel_ready_o, output, 1, the holding register is empty.
REQ-009 SHALL have port pixel_data_i, input, PIX_W, pixel data in GRB order, MSB first.
REQ-010 SHALL have port pixel_last_i, input, 1, the offered pixel is the last of the frame.
REQ-011 SHALL have port led_ctl_o, output, 1, registered one-wire LED data line.
REQ-012 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port underrun_o, output, 1, one-cycle pulse on underrun.

Function
REQ-014 SHALL transfer a pixel on a clock edge where pixel_valid_i and pixel_ready_o are both 1, into a one-entry holding register with a last flag; pixel_ready_o = holding register empty.
REQ-015 SHALL implement states IDLE, SHIFT, GAP and LATCH.
REQ-016 IDLE: when the holding register is full, SHALL move it into the shift register on the next edge and enter SHIFT at bit PIX_W-1.
REQ-017 SHIFT: led_ctl_o SHALL be 1 for bit-counter values 0..TxH-1 and 0 for values TxH..BIT_CYCLES-1, where TxH is T1H_CYCLES for a 1 bit and T0H_CYCLES for a 0 bit.
REQ-018 SHALL have a latency of 2 clk_i cycles from the acceptance edge in IDLE to the first rising edge of led_ctl_o.
REQ-019 At the end of bit 0 of a pixel without the last flag: if the holding register is full, SHALL reload with no gap cycle; otherwise SHALL enter GAP.
REQ-020 At the end of bit 0 of a pixel with the last flag, SHALL enter LATCH.
REQ-021 GAP: SHALL drive led_ctl_o low; SHALL resume SHIFT on the first cycle the holding register is full; if GAP_CNT reaches LATCH_CYCLES-1 first, SHALL pulse underrun_o and enter IDLE.
REQ-022 LATCH: SHALL drive led_ctl_o low for exactly LATCH_CYCLES cycles, then enter IDLE; the holding register SHALL still accept a pixel during LATCH.
REQ-023 The bit counter SHALL wrap from BIT_CYCLES-1 to 0; counter widths SHALL be $clog2 of the largest parameter.
REQ-024 If accept and load occur on the same edge, the register SHALL end full, containing the new pixel.
REQ-025 Parameters SHALL satisfy T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; this SHALL be checked in simulation only.

Reset
REQ-026 Asserting resetn_i low SHALL, asynchronously and at any point including mid-bit, force: state IDLE, led_ctl_o=0, pixel_ready_o=1, busy_o=0, underrun_o=0, counters 0, holding register empty.
REQ-027 Deassertion of resetn_i SHALL be synchronous to clk_i; the first accept SHALL be possible on the first edge after release.

Configuration
REQ-028 With WS2812_RGBW_EN defined, PIX_W SHALL be 32 and the order SHALL be GRBW.
REQ-029 Without WS2812_RGBW_EN, PIX_W SHALL be 24 and the order SHALL be GRB; no other behaviour SHALL differ.

Structure
REQ-030 Package ws2812_pkg SHALL hold the state enum, PIX_W derivation and default timing constants.
REQ-031 Bit-period counter and high-time compare SHALL be sub-module ws2812_bit_timer.

Verification
REQ-032 Single 24-bit pixel 0xFF0055 with last=1 -> bits: eight 40-cycle highs, eight 20-cycle highs, then 0101_0101; each bit 63 cycles; line low 15000 cycles; busy_o falls.
REQ-033 Three back-to-back pixels with valid held high -> 72 contiguous bit periods with no gap; pixel_ready_o re-asserts once per pixel.
REQ-034 Valid withheld 200 cycles after pixel 1 (not last) -> GAP low for 200 cycles, pixel 2 resumes, no underrun_o pulse.
REQ-035 Valid withheld 15000 cycles after a non-last pixel -> one underrun_o pulse, state IDLE, busy_o=0.
REQ-036 resetn_i asserted at cycle 10 of a 1-bit high phase -> led_ctl_o=0 immediately; next pixel after release is encoded correctly from its MSB.
REQ-037 With WS2812_RGBW_EN, pixel 0x00000001 last=1 -> 31 zero bits, one 1 bit, then latch.
